// File: rtl/fu_issue_station.sv
// Reservation station in front of one functional unit: holds renamed instructions,
// snoops result broadcasts for operand wakeup, issues one ready entry per cycle.
// Optional macro FU_ISSUE_OLDEST_FIRST_EN: age-matrix oldest-first select (default: lowest index).

module fu_issue_entry #(
  parameter int PRN_W = 7,
  parameter int ID_W  = 6,
  parameter int N_CDB = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr,
  input  logic [31:0]                  wr_inst,
  input  logic [ID_W-1:0]              wr_id,
  input  logic [2:0][PRN_W-1:0]        wr_tag,
  input  logic [2:0]                   wr_rdy,
  input  logic [2:0][63:0]             wr_val,
  input  logic [2:0][PRN_W-1:0]        wr_out_prn,
  input  logic [N_CDB-1:0]             cdb_valid,
  input  logic [N_CDB-1:0][PRN_W-1:0]  cdb_prn,
  input  logic [N_CDB-1:0][63:0]       cdb_data,
  output logic                         valid,
  output logic                         rdy_all,
  output logic [31:0]                  inst,
  output logic [ID_W-1:0]              inst_id,
  output logic [2:0][PRN_W-1:0]        out_prn,
  output logic [2:0][63:0]             val
);
  logic [2:0][PRN_W-1:0] tag;
  logic [2:0]            rdy;
  logic [2:0]            hit;
  logic [2:0][63:0]      hit_data;

  // On a write the incoming tag is matched, so a same-cycle broadcast is not lost.
  // Descending scan lets the lowest matching port win.
  always_comb begin
    hit      = '0;
    hit_data = '0;
    for (int s = 0; s < 3; s++) begin
      for (int k = N_CDB-1; k >= 0; k--) begin
        if (cdb_valid[k] && cdb_prn[k] == (wr ? wr_tag[s] : tag[s])) begin
          hit[s]      = 1'b1;
          hit_data[s] = cdb_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      inst    <= '0;
      inst_id <= '0;
      out_prn <= '0;
      tag     <= '0;
      rdy     <= '0;
      val     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid   <= 1'b1;
      inst    <= wr_inst;
      inst_id <= wr_id;
      out_prn <= wr_out_prn;
      tag     <= wr_tag;
      for (int s = 0; s < 3; s++) begin
        rdy[s] <= wr_rdy[s] | hit[s];
        val[s] <= wr_rdy[s] ? wr_val[s] : hit_data[s];
      end
    end else if (valid) begin
      for (int s = 0; s < 3; s++) begin
        if (!rdy[s] && hit[s]) begin
          rdy[s] <= 1'b1;
          val[s] <= hit_data[s];
        end
      end
    end
  end

  assign rdy_all = &rdy;
endmodule

module fu_issue_station #(
  parameter int ENTRIES = 4,
  parameter int PRN_W   = 7,
  parameter int ID_W    = 6,
  parameter int N_CDB   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  logic [31:0]                   disp_inst,
  input  logic [ID_W-1:0]               disp_inst_id,
  input  logic [2:0][PRN_W-1:0]         disp_src_prn,
  input  logic [2:0]                    disp_src_rdy,
  input  logic [2:0][63:0]              disp_src_val,
  input  logic [2:0][PRN_W-1:0]         disp_out_prn,
  input  logic [N_CDB-1:0]              cdb_valid,
  input  logic [N_CDB-1:0][PRN_W-1:0]   cdb_prn,
  input  logic [N_CDB-1:0][63:0]        cdb_data,
  input  logic                          fu_ready,
  output logic                          inst_valid,
  output logic [31:0]                   inst,
  output logic [ID_W-1:0]               inst_id,
  output logic [2:0][63:0]              op,
  output logic [2:0][PRN_W-1:0]         out_prn,
  output logic [$clog2(ENTRIES):0]      occupancy
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = IDX_W + 1;

  typedef struct packed {
    logic [31:0]           inst;
    logic [ID_W-1:0]       id;
    logic [2:0][PRN_W-1:0] out_prn;
    logic [2:0][63:0]      op;
  } iss_t;

  logic [ENTRIES-1:0]                  e_valid, e_rdy, cand, elig, wr_oh, clr;
  logic [ENTRIES-1:0][31:0]            e_inst;
  logic [ENTRIES-1:0][ID_W-1:0]        e_id;
  logic [ENTRIES-1:0][2:0][PRN_W-1:0]  e_out_prn;
  logic [ENTRIES-1:0][2:0][63:0]       e_val;
  logic [IDX_W-1:0]                    alloc_idx, sel_idx;
  logic                                acc, sel_any, iss;
  iss_t                                sel_pl, iss_q;
  logic                                iss_vld;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    fu_issue_entry #(.PRN_W(PRN_W), .ID_W(ID_W), .N_CDB(N_CDB)) u_ent (
      .clk(clk), .rst(rst), .clr(clr[g]), .wr(wr_oh[g]),
      .wr_inst(disp_inst), .wr_id(disp_inst_id), .wr_tag(disp_src_prn),
      .wr_rdy(disp_src_rdy), .wr_val(disp_src_val), .wr_out_prn(disp_out_prn),
      .cdb_valid(cdb_valid), .cdb_prn(cdb_prn), .cdb_data(cdb_data),
      .valid(e_valid[g]), .rdy_all(e_rdy[g]), .inst(e_inst[g]), .inst_id(e_id[g]),
      .out_prn(e_out_prn[g]), .val(e_val[g])
    );
  end

  // Dispatch: lowest free entry, availability from registered valid bits only.
  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--)
      if (!e_valid[i]) alloc_idx = IDX_W'(i);
  end

  assign disp_ready = ~&e_valid;
  assign acc        = disp_valid && disp_ready && !flush;
  assign cand       = e_valid & e_rdy;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      wr_oh[i] = acc && (alloc_idx == IDX_W'(i));
      clr[i]   = flush || (iss && (sel_idx == IDX_W'(i)));
    end
  end

`ifdef FU_ISSUE_OLDEST_FIRST_EN
  // older[i][j] set means entry i was dispatched before entry j.
  logic [ENTRIES-1:0][ENTRIES-1:0] older, older_nxt;

  always_comb begin
    older_nxt = older;
    if (acc) begin
      for (int j = 0; j < ENTRIES; j++) begin
        older_nxt[alloc_idx][j] = 1'b0;
        older_nxt[j][alloc_idx] = e_valid[j];
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (clr[i]) begin
        for (int j = 0; j < ENTRIES; j++) begin
          older_nxt[i][j] = 1'b0;
          older_nxt[j][i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    elig = cand;
    for (int i = 0; i < ENTRIES; i++)
      for (int j = 0; j < ENTRIES; j++)
        if (cand[j] && older[j][i]) elig[i] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) older <= '0;
    else     older <= older_nxt;
  end
`else
  assign elig = cand;
`endif

  always_comb begin
    sel_any = |elig;
    sel_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--)
      if (elig[i]) sel_idx = IDX_W'(i);
  end

  assign iss = fu_ready && sel_any && !flush;

  always_comb begin
    sel_pl.inst    = e_inst[sel_idx];
    sel_pl.id      = e_id[sel_idx];
    sel_pl.out_prn = e_out_prn[sel_idx];
    sel_pl.op      = e_val[sel_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_vld   <= 1'b0;
      iss_q     <= '0;
      occupancy <= '0;
    end else begin
      iss_vld <= iss;
      if (iss) iss_q <= sel_pl;
      if (flush) occupancy <= '0;
      else       occupancy <= occupancy + OCC_W'(acc) - OCC_W'(iss);
    end
  end

  assign inst_valid = iss_vld;
  assign inst       = iss_q.inst;
  assign inst_id    = iss_q.id;
  assign out_prn    = iss_q.out_prn;
  assign op         = iss_q.op;
endmodule

// File: tb/tb_fu_issue_station.sv
// Directed bench for fu_issue_station: issue latency, wakeup, same-cycle capture,
// full/drain ordering, flush and asynchronous reset.
module tb_fu_issue_station;
  localparam int ENTRIES = 4;
  localparam int PRN_W   = 7;
  localparam int ID_W    = 6;
  localparam int N_CDB   = 2;

  logic                        clk = 1'b0;
  logic                        rst, flush, disp_valid, disp_ready, fu_ready, inst_valid;
  logic [31:0]                 disp_inst, inst;
  logic [ID_W-1:0]             disp_inst_id, inst_id;
  logic [2:0][PRN_W-1:0]       disp_src_prn, disp_out_prn, out_prn;
  logic [2:0]                  disp_src_rdy;
  logic [2:0][63:0]            disp_src_val, op;
  logic [N_CDB-1:0]            cdb_valid;
  logic [N_CDB-1:0][PRN_W-1:0] cdb_prn;
  logic [N_CDB-1:0][63:0]      cdb_data;
  logic [$clog2(ENTRIES):0]    occupancy;

  int tests = 0;
  int fails = 0;

  fu_issue_station #(.ENTRIES(ENTRIES), .PRN_W(PRN_W), .ID_W(ID_W), .N_CDB(N_CDB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_inst(disp_inst), .disp_inst_id(disp_inst_id), .disp_src_prn(disp_src_prn),
    .disp_src_rdy(disp_src_rdy), .disp_src_val(disp_src_val), .disp_out_prn(disp_out_prn),
    .cdb_valid(cdb_valid), .cdb_prn(cdb_prn), .cdb_data(cdb_data), .fu_ready(fu_ready),
    .inst_valid(inst_valid), .inst(inst), .inst_id(inst_id), .op(op), .out_prn(out_prn),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [ID_W-1:0] id, input logic [2:0] rdy,
                      input logic [63:0] v0, input logic [63:0] v1, input logic [63:0] v2,
                      input logic [PRN_W-1:0] t0, input logic [PRN_W-1:0] t1);
    disp_valid      = 1'b1;
    disp_inst_id    = id;
    disp_inst       = 32'hC0DE_0000 | 32'(id);
    disp_src_rdy    = rdy;
    disp_src_val[0] = v0;
    disp_src_val[1] = v1;
    disp_src_val[2] = v2;
    disp_src_prn[0] = t0;
    disp_src_prn[1] = t1;
    disp_src_prn[2] = 7'd127;
    disp_out_prn[0] = 7'd1;
    disp_out_prn[1] = 7'd2;
    disp_out_prn[2] = 7'd3;
  endtask

  logic [ID_W-1:0] exp_order [5];

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; fu_ready = 1'b0;
    disp_inst = '0; disp_inst_id = '0; disp_src_prn = '0; disp_src_rdy = '0;
    disp_src_val = '0; disp_out_prn = '0; cdb_valid = '0; cdb_prn = '0; cdb_data = '0;
    #3;
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_disp_ready", disp_ready, 1'b1);
    chk("rst_op", op, 0);
    chk("rst_inst", inst, 0);
    #9 rst = 1'b0;

    // Basic issue latency: accept at E, inst_valid visible after E+1
    fu_ready = 1'b1;
    disp(6'd5, 3'b111, 64'h11, 64'h22, 64'h0, 7'd0, 7'd0);
    step();
    disp_valid = 1'b0;
    chk("t1_occ_after_accept", occupancy, 1);
    chk("t1_no_early_issue", inst_valid, 1'b0);
    step();
    chk("t1_inst_valid", inst_valid, 1'b1);
    chk("t1_inst_id", inst_id, 5);
    chk("t1_op", op, {64'h0, 64'h22, 64'h11});
    chk("t1_inst", inst, 32'hC0DE_0005);
    chk("t1_out_prn", out_prn, {7'd3, 7'd2, 7'd1});
    step();
    chk("t1_pulse_end", inst_valid, 1'b0);
    chk("t1_op_hold", op, {64'h0, 64'h22, 64'h11});
    chk("t1_occ_empty", occupancy, 0);

    // Wakeup from broadcast port 1
    disp(6'd1, 3'b101, 64'hA, 64'h0, 64'hC, 7'd0, 7'd9);
    step();
    disp_valid = 1'b0;
    step();
    chk("t2_waiting", inst_valid, 1'b0);
    cdb_valid = 2'b10; cdb_prn[1] = 7'd9; cdb_data[1] = 64'hDEAD;
    step();
    cdb_valid = '0;
    chk("t2_no_issue_at_capture", inst_valid, 1'b0);
    step();
    chk("t2_inst_valid", inst_valid, 1'b1);
    chk("t2_inst_id", inst_id, 1);
    chk("t2_op", op, {64'hC, 64'hDEAD, 64'hA});
    step();

    // Same-cycle capture; both ports match, lowest port wins
    disp(6'd2, 3'b110, 64'h0, 64'h5, 64'h6, 7'd3, 7'd0);
    cdb_valid = 2'b11; cdb_prn[0] = 7'd3; cdb_data[0] = 64'h7;
    cdb_prn[1] = 7'd3; cdb_data[1] = 64'h99;
    step();
    disp_valid = 1'b0; cdb_valid = '0;
    chk("t3_occ", occupancy, 1);
    step();
    chk("t3_inst_valid", inst_valid, 1'b1);
    chk("t3_inst_id", inst_id, 2);
    chk("t3_op", op, {64'h6, 64'h5, 64'h7});
    step();

    // Fill with FU stalled, then drain with a slot reuse after first issue
    fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(6'(10 + i), 3'b111, 64'(10 + i), 64'h0, 64'h0, 7'd0, 7'd0);
      step();
    end
    disp_valid = 1'b0;
    chk("t4_full_ready", disp_ready, 1'b0);
    chk("t4_full_occ", occupancy, 4);
    chk("t4_stalled", inst_valid, 1'b0);
`ifdef FU_ISSUE_OLDEST_FIRST_EN
    exp_order = '{6'd10, 6'd11, 6'd12, 6'd13, 6'd20};
`else
    exp_order = '{6'd10, 6'd11, 6'd20, 6'd12, 6'd13};
`endif
    fu_ready = 1'b1;
    step();
    chk("t4_first_valid", inst_valid, 1'b1);
    chk("t4_first_id", inst_id, exp_order[0]);
    chk("t4_ready_after_issue", disp_ready, 1'b1);
    chk("t4_occ_after_issue", occupancy, 3);
    disp(6'd20, 3'b111, 64'h20, 64'h0, 64'h0, 7'd0, 7'd0);
    for (int i = 1; i < 5; i++) begin
      step();
      disp_valid = 1'b0;
      chk("t4_drain_valid", inst_valid, 1'b1);
      chk("t4_drain_id", inst_id, exp_order[i]);
    end
    step();
    chk("t4_drained", inst_valid, 1'b0);
    chk("t4_drained_occ", occupancy, 0);

    // Flush drops same-cycle dispatch and suppresses issue
    fu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(6'(30 + i), 3'b111, 64'h1, 64'h2, 64'h3, 7'd0, 7'd0);
      step();
    end
    chk("t5_occ3", occupancy, 3);
    disp(6'd33, 3'b111, 64'h1, 64'h2, 64'h3, 7'd0, 7'd0);
    flush = 1'b1; fu_ready = 1'b1;
    step();
    flush = 1'b0; disp_valid = 1'b0;
    chk("t5_occ_flushed", occupancy, 0);
    chk("t5_no_issue", inst_valid, 1'b0);
    chk("t5_disp_ready", disp_ready, 1'b1);
    step();
    chk("t5_dispatch_dropped", inst_valid, 1'b0);

    // Asynchronous reset while an issue pulse is high
    disp(6'd40, 3'b111, 64'h40, 64'h41, 64'h42, 7'd0, 7'd0);
    step();
    disp_valid = 1'b0;
    step();
    chk("t6_pre_valid", inst_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", inst_valid, 1'b0);
    chk("t6_rst_id", inst_id, 0);
    chk("t6_rst_op", op, 0);
    chk("t6_rst_out_prn", out_prn, 0);
    chk("t6_rst_inst", inst, 0);
    #2 rst = 1'b0;
    step();
    chk("t6_after_rst", inst_valid, 1'b0);
    chk("t6_after_rst_occ", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
